// File: rtl/ahb_sram_wait_responder.sv
// ---------------------------------------------------------------------------
// ahb_sram_wait_responder
//
// AHB-Lite slave backed by an on-chip word memory. Every data phase is
// stretched by a configurable number of wait states (separate counts for
// NSEQ and SEQ transfers). Transfers that fall in a configurable address
// window, or ask for a size wider than the bus, get a two-cycle ERROR
// response and never touch memory.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ahbls_hready_resp   o  1 = this slave completes the current data phase
//   ahbls_hready        i  bus-level HREADY (qualifies address phases)
//   ahbls_hresp         o  1 = ERROR response
//   ahbls_haddr         i  address-phase address
//   ahbls_hwrite        i  1 = write
//   ahbls_htrans        i  IDLE/BUSY/NSEQ/SEQ
//   ahbls_hsize         i  log2 of transfer size in bytes
//   ahbls_hburst        i  burst type (beats are handled from haddr only)
//   ahbls_hprot         i  ignored
//   ahbls_hmastlock     i  ignored
//   ahbls_hwdata        i  write data, sampled in the completing cycle
//   ahbls_hrdata        o  read data, nonzero only in a completing read cycle
// ---------------------------------------------------------------------------
module ahb_sram_wait_responder #(
    parameter int unsigned W_ADDR    = 32,
    parameter int unsigned W_DATA    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned WAIT_NSEQ = 2,
    parameter int unsigned WAIT_SEQ  = 0,
    parameter int unsigned ERR_BASE  = 32'h0000_F000,
    parameter int unsigned ERR_SIZE  = 32'h100
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ahbls_hready_resp,
    input  logic              ahbls_hready,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata
);

    localparam int unsigned NB    = W_DATA / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned W_MAX = (WAIT_NSEQ > WAIT_SEQ) ? WAIT_NSEQ : WAIT_SEQ;
    // Counter holds (waits - 1), so it needs to reach W_MAX - 1.
    localparam int unsigned CNT_W = (W_MAX > 2) ? $clog2(W_MAX) : 1;

    localparam logic [63:0] ERR_LO = 64'(ERR_BASE);
    localparam logic [63:0] ERR_HI = 64'(ERR_BASE) + 64'(ERR_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR_PH0,
        S_ERR_PH1
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Byte lanes for a transfer; the offset is aligned down to the size.
    function automatic logic [NB-1:0] lane_mask(input logic [OFF_W-1:0] off,
                                                input logic [2:0]       size);
        int unsigned nbytes;
        int unsigned base;
        nbytes = 32'd1 << size;
        base   = 32'(off) & ~(nbytes - 32'd1);
        return NB'(((32'd1 << nbytes) - 32'd1) << base);
    endfunction

    function automatic logic is_err(input logic [W_ADDR-1:0] a,
                                    input logic [2:0]        size);
        logic [63:0] a64;
        a64 = 64'(a);
        return ((a64 >= ERR_LO) && (a64 < ERR_HI)) || (32'(size) > OFF_W);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W_ADDR-1:0]  addr_q;
    logic               write_q;
    logic [2:0]         size_q;
    logic               seq_q;
    logic               hready_resp_q;
    logic               hresp_q;
    logic               rd_en_q, rd_en_d;
    logic [NB-1:0]      byp_be_q, byp_be_d;

    logic [W_DATA-1:0]  mem [DEPTH];
    logic [W_DATA-1:0]  mem_rd_q;
    logic [W_DATA-1:0]  byp_data_q;

    logic               accept;
    logic               acc_err;
    int unsigned        acc_wait;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [NB-1:0]      wr_be;
    logic [W_DATA-1:0]  wr_bmask;
    logic [W_DATA-1:0]  byp_bmask;

    // Only states that complete a data phase can take a new address phase.
    assign accept = ahbls_hready && ahbls_htrans[1]
                 && (state_q inside {S_IDLE, S_DATA, S_ERR_PH1});

    assign wr_en  = (state_q == S_DATA) && write_q;
    assign wr_idx = addr_q[OFF_W +: IDX_W];
    assign wr_be  = lane_mask(addr_q[OFF_W-1:0], size_q);

    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign wr_bmask[g*8 +: 8]  = {8{wr_be[g]}};
        assign byp_bmask[g*8 +: 8] = {8{byp_be_q[g]}};
    end

    // -----------------------------------------------------------------------
    // Next-state decode
    // -----------------------------------------------------------------------
    always_comb begin
        acc_err  = is_err(ahbls_haddr, ahbls_hsize);
        acc_wait = ahbls_htrans[0] ? WAIT_SEQ : WAIT_NSEQ;
        state_d  = state_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ERR_PH0: begin
                state_d = S_ERR_PH1;
            end
            default: begin
                if (accept) begin
                    if (acc_err) begin
                        state_d = S_ERR_PH0;
                    end else if (acc_wait != 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(acc_wait - 32'd1);
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Memory is read one edge ahead of the completing cycle. Entering
        // S_DATA from S_WAIT uses the registered phase; a zero-wait accept
        // uses the live address phase.
        if (state_q == S_WAIT) begin
            rd_idx  = addr_q[OFF_W +: IDX_W];
            rd_en_d = (state_d == S_DATA) && !write_q;
        end else begin
            rd_idx  = ahbls_haddr[OFF_W +: IDX_W];
            rd_en_d = (state_d == S_DATA) && !ahbls_hwrite;
        end

        // A write committing on the same edge as that read is not yet in
        // the array; remember its lanes so the read output can merge them.
        byp_be_d = (wr_en && rd_en_d && (rd_idx == wr_idx)) ? wr_be : '0;
    end

    // -----------------------------------------------------------------------
    // FSM, registered phase and registered responses
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            size_q        <= '0;
            seq_q         <= 1'b0;
            hready_resp_q <= 1'b1;
            hresp_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            byp_be_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= ahbls_haddr;
                write_q <= ahbls_hwrite;
                size_q  <= ahbls_hsize;
                seq_q   <= ahbls_htrans[0];
            end
            hready_resp_q <= !(state_d inside {S_WAIT, S_ERR_PH0});
            hresp_q       <= state_d inside {S_ERR_PH0, S_ERR_PH1};
            rd_en_q       <= rd_en_d;
            byp_be_q      <= byp_be_d;
        end
    end

    // -----------------------------------------------------------------------
    // Memory array (not reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_bmask) | (ahbls_hwdata & wr_bmask);
        end
        if (rd_en_d) begin
            mem_rd_q <= mem[rd_idx];
        end
        byp_data_q <= ahbls_hwdata;
    end

    assign ahbls_hready_resp = hready_resp_q;
    assign ahbls_hresp       = hresp_q;
    assign ahbls_hrdata      = rd_en_q ? ((mem_rd_q & ~byp_bmask) | (byp_data_q & byp_bmask))
                                       : '0;

    // Inputs and phase bits that carry no function in this slave.
    logic unused_ok;
    assign unused_ok = ^{ahbls_hprot, ahbls_hmastlock, ahbls_hburst, seq_q, addr_q};

endmodule
